// File: rtl/amo_rmw_unit_pkg.sv
// amo_rmw_unit_pkg: shared AMO request/response types, the RMW FSM states and constants for amo_rmw_unit
package amo_rmw_unit_pkg;
    localparam int unsigned DEF_PLEN = 56;
    localparam logic [1:0] SIZE_D = 2'b11;
    localparam logic [63:0] AMO_SC_FAIL = 64'd1;
    typedef enum logic [3:0] {
        AMO_NONE = 4'd0, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
        AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
    } amo_t;
    typedef struct packed {
        logic        req;
        amo_t        amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;
    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;
    typedef enum logic [2:0] {IDLE, READ, READ_WAIT, WRITE, ACK} amo_rmw_state_e;
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational AMO modify step; W ops work on the low 32 bits and replicate the result into both halves
// Ports: op/size select the operation, old is the current memory value, operand is the AMO data, new_value is lane-ready write data.
module amo_alu import amo_rmw_unit_pkg::*; (
    input  amo_t        op,
    input  logic [1:0]  size,
    input  logic [63:0] old,
    input  logic [63:0] operand,
    output logic [63:0] new_value
);
    logic is_w;
    logic lt_s;
    logic lt_u;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    // Sign-extending both W operands keeps signed and unsigned ordering identical to a 32-bit compare.
    always_comb begin
        is_w = size != SIZE_D;
        a = is_w ? {{32{old[31]}}, old[31:0]} : old;
        b = is_w ? {{32{operand[31]}}, operand[31:0]} : operand;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        case (op)
            AMO_ADD:  r = a + b;
            AMO_AND:  r = a & b;
            AMO_OR:   r = a | b;
            AMO_XOR:  r = a ^ b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MAXU: r = lt_u ? b : a;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MINU: r = lt_u ? a : b;
            default:  r = b;
        endcase
        new_value = is_w ? {r[31:0], r[31:0]} : r;
    end
endmodule

// File: rtl/amo_rmw_unit.sv
// amo_rmw_unit: memory-side AMO responder doing read-modify-write on a single-ported memory, with optional LR/SC reservation
// Ports: amo_req_i/amo_resp_o to the LSU AMO buffer; mem_* request/grant/rvalid memory port; reservation_valid_o for visibility.
// Build option: define AMO_LRSC_EN to include the LR/SC reservation; otherwise LR is a plain read and SC always fails.
module amo_rmw_unit import amo_rmw_unit_pkg::*; #(
    parameter int unsigned PLEN = DEF_PLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  amo_req_t        amo_req_i,
    output amo_resp_t       amo_resp_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [PLEN-1:0] mem_addr_o,
    output logic [63:0]     mem_wdata_o,
    output logic [7:0]      mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [63:0]     mem_rdata_i,
    output logic            reservation_valid_o
);
    amo_rmw_state_e state_q, state_d;
    amo_t op_q, op_d;
    logic [1:0] size_q, size_d;
    logic [PLEN-1:2] addr_q, addr_d;
    logic [63:0] opb_q, opb_d, wdata_q, wdata_d, result_q, result_d;
    logic [7:0] be_q, be_d;
    logic req_q, req_d, we_q, we_d, ack_q, ack_d, hold_q, hold_d;
    logic is_w_in, lane_in, is_rmw_in, accept, sc_ok, is_w_q;
    logic [7:0] be_in;
    logic [31:0] lane_word;
    logic [63:0] old_ext, new_value;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{amo_req_i.operand_a[63:PLEN], amo_req_i.operand_a[1:0]};
    assign is_w_in = amo_req_i.size != SIZE_D;
    assign lane_in = amo_req_i.operand_a[2];
    assign be_in = !is_w_in ? 8'hFF : lane_in ? 8'hF0 : 8'h0F;
    assign is_rmw_in = amo_req_i.amo_op inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
                                                AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU};
    // hold_q marks the cycle right after an ack, when the initiator may still be holding req.
    assign accept = state_q == IDLE && amo_req_i.req && !hold_q;
    assign is_w_q = size_q != SIZE_D;
    assign lane_word = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign old_ext = is_w_q ? {{32{lane_word[31]}}, lane_word} : mem_rdata_i;
    amo_alu u_alu (
        .op        (op_q),
        .size      (size_q),
        .old       (old_ext),
        .operand   (opb_q),
        .new_value (new_value)
    );
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        size_d = size_q;
        addr_d = addr_q;
        opb_d = opb_q;
        req_d = req_q;
        we_d = we_q;
        wdata_d = wdata_q;
        be_d = be_q;
        result_d = result_q;
        ack_d = 1'b0;
        hold_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                op_d = amo_req_i.amo_op;
                size_d = amo_req_i.size;
                addr_d = amo_req_i.operand_a[PLEN-1:2];
                opb_d = amo_req_i.operand_b;
                be_d = be_in;
                if (amo_req_i.amo_op == AMO_SC) begin
                    if (sc_ok) begin
                        state_d = WRITE;
                        req_d = 1'b1;
                        we_d = 1'b1;
                        wdata_d = is_w_in ? {2{amo_req_i.operand_b[31:0]}} : amo_req_i.operand_b;
                    end else begin
                        state_d = ACK;
                        ack_d = 1'b1;
                        result_d = AMO_SC_FAIL;
                    end
                end else if (amo_req_i.amo_op == AMO_LR || is_rmw_in) begin
                    state_d = READ;
                    req_d = 1'b1;
                    we_d = 1'b0;
                end else begin
                    state_d = ACK;
                    ack_d = 1'b1;
                    result_d = '0;
                end
            end
            READ: if (mem_gnt_i) begin
                req_d = 1'b0;
                state_d = READ_WAIT;
            end
            READ_WAIT: if (mem_rvalid_i) begin
                result_d = old_ext;
                if (op_q == AMO_LR) begin
                    state_d = ACK;
                    ack_d = 1'b1;
                end else begin
                    state_d = WRITE;
                    req_d = 1'b1;
                    we_d = 1'b1;
                    wdata_d = new_value;
                end
            end
            WRITE: if (mem_gnt_i) begin
                req_d = 1'b0;
                we_d = 1'b0;
                state_d = ACK;
                ack_d = 1'b1;
                result_d = op_q == AMO_SC ? '0 : result_q;
            end
            ACK: begin
                state_d = IDLE;
                hold_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q <= AMO_NONE;
            size_q <= '0;
            addr_q <= '0;
            opb_q <= '0;
            req_q <= 1'b0;
            we_q <= 1'b0;
            wdata_q <= '0;
            be_q <= '0;
            result_q <= '0;
            ack_q <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            size_q <= size_d;
            addr_q <= addr_d;
            opb_q <= opb_d;
            req_q <= req_d;
            we_q <= we_d;
            wdata_q <= wdata_d;
            be_q <= be_d;
            result_q <= result_d;
            ack_q <= ack_d;
            hold_q <= hold_d;
        end
    end
`ifdef AMO_LRSC_EN
    logic res_valid_q, res_valid_d, res_w_q, res_w_d, res_lane_q, res_lane_d, addr_match;
    logic [PLEN-1:3] res_addr_q, res_addr_d;
    always_comb begin
        addr_match = res_valid_q && res_addr_q == amo_req_i.operand_a[PLEN-1:3];
        sc_ok = addr_match && res_w_q == is_w_in && (!is_w_in || res_lane_q == lane_in);
        res_valid_d = res_valid_q;
        res_w_d = res_w_q;
        res_lane_d = res_lane_q;
        res_addr_d = res_addr_q;
        if (accept && (amo_req_i.amo_op == AMO_SC || (is_rmw_in && addr_match))) res_valid_d = 1'b0;
        if (state_q == READ_WAIT && mem_rvalid_i && op_q == AMO_LR) begin
            res_valid_d = 1'b1;
            res_w_d = is_w_q;
            res_lane_d = addr_q[2];
            res_addr_d = addr_q[PLEN-1:3];
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_w_q <= 1'b0;
            res_lane_q <= 1'b0;
            res_addr_q <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_w_q <= res_w_d;
            res_lane_q <= res_lane_d;
            res_addr_q <= res_addr_d;
        end
    end
    assign reservation_valid_o = res_valid_q;
`else
    assign sc_ok = 1'b0;
    assign reservation_valid_o = 1'b0;
`endif
    assign amo_resp_o.ack = ack_q;
    assign amo_resp_o.result = result_q;
    assign mem_req_o = req_q;
    assign mem_we_o = we_q;
    assign mem_addr_o = {addr_q[PLEN-1:3], 3'b000};
    assign mem_wdata_o = wdata_q;
    assign mem_be_o = be_q;
endmodule

// File: tb/tb_amo_rmw_unit.sv
// tb_amo_rmw_unit: directed checks of amo_rmw_unit against a bench memory responder
module tb_amo_rmw_unit;
    import amo_rmw_unit_pkg::*;
    localparam int PLEN = DEF_PLEN;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SD = 2'b11;
`ifdef AMO_LRSC_EN
    localparam bit LRSC = 1'b1;
`else
    localparam bit LRSC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    amo_req_t amo_req;
    amo_resp_t amo_resp;
    logic mem_req_o, mem_we_o, resv;
    logic mem_gnt_i = 1'b0;
    logic mem_rvalid_i = 1'b0;
    logic [PLEN-1:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i = '0;
    logic [7:0] mem_be_o;
    int n_chk = 0, n_pass = 0;
    int stall_n = 0, wait_cnt = 0, wr_cnt = 0, unstable = 0;
    logic [63:0] mem [logic [PLEN-1:0]];
    logic [63:0] last_wdata = '0, w;
    logic [7:0] last_be = '0;
    logic [PLEN-1:0] last_waddr = '0, rd_addr = '0;
    logic rd_pend = 1'b0;
    logic p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [PLEN-1:0] p_addr = '0;
    logic [63:0] p_wdata = '0;
    logic [7:0] p_be = '0;

    amo_rmw_unit dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .amo_req_i           (amo_req),
        .amo_resp_o          (amo_resp),
        .mem_req_o           (mem_req_o),
        .mem_we_o            (mem_we_o),
        .mem_addr_o          (mem_addr_o),
        .mem_wdata_o         (mem_wdata_o),
        .mem_be_o            (mem_be_o),
        .mem_gnt_i           (mem_gnt_i),
        .mem_rvalid_i        (mem_rvalid_i),
        .mem_rdata_i         (mem_rdata_i),
        .reservation_valid_o (resv)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mrd(input logic [PLEN-1:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i && mem_we_o) begin
            w = mrd(mem_addr_o);
            for (int i = 0; i < 8; i++) if (mem_be_o[i]) w[8*i +: 8] = mem_wdata_o[8*i +: 8];
            mem[mem_addr_o] = w;
            wr_cnt++;
            last_wdata = mem_wdata_o;
            last_be = mem_be_o;
            last_waddr = mem_addr_o;
        end
        rd_pend = mem_req_o && mem_gnt_i && !mem_we_o;
        rd_addr = mem_addr_o;
    end

    always @(negedge clk) begin
        if (p_req && !p_gnt && (mem_req_o !== 1'b1 || mem_we_o !== p_we || mem_addr_o !== p_addr ||
            mem_wdata_o !== p_wdata || mem_be_o !== p_be)) unstable++;
        if (mem_req_o && wait_cnt < stall_n) begin
            mem_gnt_i = 1'b0;
            wait_cnt++;
        end else begin
            mem_gnt_i = mem_req_o;
            wait_cnt = 0;
        end
        p_req = mem_req_o;
        p_gnt = mem_gnt_i;
        p_we = mem_we_o;
        p_addr = mem_addr_o;
        p_wdata = mem_wdata_o;
        p_be = mem_be_o;
        mem_rvalid_i = rd_pend;
        mem_rdata_i = rd_pend ? mrd(rd_addr) : 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_amo(input amo_t op, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] b,
                          output int cyc, output logic [63:0] res, output int reqs);
        @(negedge clk);
        amo_req = '{req: 1'b1, amo_op: op, size: sz, operand_a: a, operand_b: b};
        cyc = -1;
        res = 'x;
        reqs = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (mem_req_o) reqs++;
            if (amo_resp.ack) begin
                cyc = n;
                res = amo_resp.result;
                break;
            end
        end
        @(negedge clk);
        amo_req.req = 1'b0;
    endtask

    initial begin
        int cyc, reqs, wr_before;
        logic [63:0] res;
        amo_req = '0;
        mem[56'h1000] = 64'd5;
        mem[56'h2000] = 64'h12345678_9ABCDEF0;
        mem[56'h3000] = 64'h00000002_80000001;
        mem[56'h4000] = 64'h80000000_00000000;
        mem[56'h5000] = 64'h10;
        mem[56'h6000] = 64'h77;
        repeat (3) @(negedge clk);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_ack", amo_resp.ack, 0);
        chk("rst_result", amo_resp.result, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_resv", resv, 0);
        rst_n = 1'b1;

        do_amo(AMO_ADD, SD, 64'h1000, 64'd3, cyc, res, reqs);
        chk("add_d_cycle", cyc, 4);
        chk("add_d_result", res, 64'd5);
        chk("add_d_wdata", last_wdata, 64'd8);
        chk("add_d_be", last_be, 8'hFF);
        chk("add_d_waddr", last_waddr, 56'h1000);
        chk("add_d_mem", mrd(56'h1000), 64'd8);

        mem[56'h1000] = 64'hFFFFFFFF_00000008;
        do_amo(AMO_ADD, SW, 64'h1004, 64'd1, cyc, res, reqs);
        chk("add_w_result", res, 64'hFFFFFFFF_FFFFFFFF);
        chk("add_w_wdata", last_wdata, 64'd0);
        chk("add_w_be", last_be, 8'hF0);
        chk("add_w_mem", mrd(56'h1000), 64'd8);

        do_amo(AMO_LR, SD, 64'h2000, 64'd0, cyc, res, reqs);
        chk("lr_d_cycle", cyc, 3);
        chk("lr_d_result", res, 64'h12345678_9ABCDEF0);
        chk("lr_d_resv", resv, LRSC);
        do_amo(AMO_SC, SD, 64'h2000, 64'hAB, cyc, res, reqs);
        chk("sc_d_cycle", cyc, LRSC ? 2 : 1);
        chk("sc_d_result", res, LRSC ? 64'd0 : 64'd1);
        chk("sc_d_mem", mrd(56'h2000), LRSC ? 64'hAB : 64'h12345678_9ABCDEF0);
        chk("sc_d_reqs", reqs, LRSC ? 1 : 0);
        chk("sc_d_resv", resv, 0);
        do_amo(AMO_SC, SD, 64'h2000, 64'hCD, cyc, res, reqs);
        chk("sc2_cycle", cyc, 1);
        chk("sc2_result", res, 64'd1);
        chk("sc2_reqs", reqs, 0);

        do_amo(AMO_LR, SW, 64'h3000, 64'd0, cyc, res, reqs);
        chk("lr_w_result", res, 64'hFFFFFFFF_80000001);
        chk("lr_w_resv", resv, LRSC);
        do_amo(AMO_SWAP, SW, 64'h3000, 64'h55, cyc, res, reqs);
        chk("swap_w_result", res, 64'hFFFFFFFF_80000001);
        chk("swap_w_wdata", last_wdata, 64'h00000055_00000055);
        chk("swap_w_be", last_be, 8'h0F);
        chk("swap_w_mem", mrd(56'h3000), 64'h00000002_00000055);
        chk("swap_w_resv", resv, 0);
        do_amo(AMO_SC, SW, 64'h3000, 64'd7, cyc, res, reqs);
        chk("sc_w_result", res, 64'd1);
        chk("sc_w_reqs", reqs, 0);
        chk("sc_w_mem", mrd(56'h3000), 64'h00000002_00000055);

        do_amo(AMO_MAX, SW, 64'h3004, 64'hFFFFFFFF, cyc, res, reqs);
        chk("max_w_result", res, 64'd2);
        chk("max_w_wdata", last_wdata, 64'h00000002_00000002);
        chk("max_w_be", last_be, 8'hF0);

        do_amo(AMO_NONE, SD, 64'h3000, 64'd9, cyc, res, reqs);
        chk("none_cycle", cyc, 1);
        chk("none_result", res, 64'd0);
        chk("none_reqs", reqs, 0);

        stall_n = 3;
        do_amo(AMO_MINU, SD, 64'h4000, 64'd1, cyc, res, reqs);
        stall_n = 0;
        chk("minu_cycle", cyc, 10);
        chk("minu_result", res, 64'h80000000_00000000);
        chk("minu_wdata", last_wdata, 64'd1);
        chk("minu_be", last_be, 8'hFF);
        chk("minu_req_cycles", reqs, 8);
        chk("minu_stable", unstable, 0);
        chk("minu_mem", mrd(56'h4000), 64'd1);

        do_amo(AMO_LR, SD, 64'h6000, 64'd0, cyc, res, reqs);
        chk("lr6_result", res, 64'h77);
        wr_before = wr_cnt;
        @(negedge clk);
        amo_req = '{req: 1'b1, amo_op: AMO_ADD, size: SD, operand_a: 64'h5000, operand_b: 64'd1};
        @(negedge clk);
        chk("rw_read_req", mem_req_o, 1);
        @(negedge clk);
        chk("rw_wait_noreq", mem_req_o, 0);
        chk("rw_resv_pre", resv, LRSC);
        rst_n = 1'b0;
        amo_req.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rw_req", mem_req_o, 0);
        chk("rw_we", mem_we_o, 0);
        chk("rw_ack", amo_resp.ack, 0);
        chk("rw_result", amo_resp.result, 0);
        chk("rw_addr", mem_addr_o, 0);
        chk("rw_be", mem_be_o, 0);
        chk("rw_resv", resv, 0);
        chk("rw_no_write", wr_cnt, wr_before);
        chk("rw_mem", mrd(56'h5000), 64'h10);
        @(negedge clk);
        rst_n = 1'b1;
        do_amo(AMO_ADD, SD, 64'h5000, 64'd1, cyc, res, reqs);
        chk("post_rst_cycle", cyc, 4);
        chk("post_rst_result", res, 64'h10);
        chk("post_rst_mem", mrd(56'h5000), 64'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
